param_wr_fifo: RTL and testbench

PARAM_WR_FIFO -- requirements
Module: param_wr_fifo

---
 rtl/wr_fifo_pkg.sv | 29 ++
 rtl/param_wr_fifo_ptr.sv | 36 +++
 rtl/param_wr_fifo.sv | 165 ++++++++++++++++
 tb/tb_param_wr_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wr_fifo_pkg.sv
// Shared sizing helpers for the parameterised write FIFO: ceiling log2 and the
// pointer/count width derivations used by param_wr_fifo and fifo_ptr.
package wr_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pointers address DEPTH entries; the count needs one extra bit to hold DEPTH itself.
    function automatic int ptrWidth(input int depth);
        return clog2(depth);
    endfunction

    function automatic int cntWidth(input int depth);
        return clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_PTR_W = ptrWidth(DEFAULT_DEPTH);
    localparam int DEFAULT_CNT_W = cntWidth(DEFAULT_DEPTH);

endpackage

// File: rtl/param_wr_fifo_ptr.sv
// fifo_ptr: PTR_W-bit wrap-around incrementing register with load enable,
// used for both the read and the write pointer of param_wr_fifo.
module fifo_ptr #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // DEPTH is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/param_wr_fifo.sv
// Synchronous first-word fall-through FIFO with flush and occupancy flags.
// Define PARAM_WR_FIFO_ERR_EN to add sticky ovf_err/udf_err flags and err_clr.
module param_wr_fifo
    import wr_fifo_pkg::*;
#(
    parameter int DATA_W = 98,
    parameter int DEPTH  = 8,
    parameter int AF_TH  = DEPTH - 1,
    parameter int AE_TH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    fifo_empty,
    output logic                    fifo_empty_bar,
    output logic                    fifo_full,
    output logic                    fifo_full_bar,
    output logic                    fifo_afull,
    output logic                    fifo_aempty,
    output logic [clog2(DEPTH):0]   fifo_cnt
`ifdef PARAM_WR_FIFO_ERR_EN
    ,
    input  logic                    err_clr,
    output logic                    ovf_err,
    output logic                    udf_err
`endif
);

    localparam int PTR_W = ptrWidth(DEPTH);
    localparam int CNT_W = cntWidth(DEPTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_TH);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic              isEmpty;
    logic              isFull;
    logic              rdAcc;
    logic              wrAcc;
    logic              memWr;
    logic [DEPTH-1:0]  wrEn;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign isEmpty = (cnt_q == '0);
    assign isFull  = (cnt_q == FULL_CNT);

    // No bypass: a read needs a stored entry, but a read frees room for a write to a full FIFO.
    assign rdAcc = rd && !isEmpty;
    assign wrAcc = wr && (!isFull || rdAcc);
    assign memWr = wrAcc && !flush && !rst;

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (rdAcc),
        .ptr_o (rdPtr)
    );

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (wrAcc),
        .ptr_o (wrPtr)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (wrAcc && !rdAcc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rdAcc && !wrAcc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        wrEn = '0;
        if (memWr) begin
            wrEn[wrPtr] = 1'b1;
        end
    end

    // Storage is deliberately left out of reset; only pointers and count define validity.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (wrEn[gi]) begin
                mem_q[gi] <= wr_data;
            end
        end
    end

    assign rd_data        = mem_q[rdPtr];
    assign fifo_empty     = isEmpty;
    assign fifo_empty_bar = !isEmpty;
    assign fifo_full      = isFull;
    assign fifo_full_bar  = !isFull;
    assign fifo_afull     = (cnt_q >= AF_CNT);
    assign fifo_aempty    = (cnt_q <= AE_CNT);
    assign fifo_cnt       = cnt_q;

`ifdef PARAM_WR_FIFO_ERR_EN
    logic ovf_q;
    logic ovf_d;
    logic udf_q;
    logic udf_d;
    logic ovfSet;
    logic udfSet;

    // A read paired with a write on an empty FIFO is a normal fill, not an underflow.
    assign ovfSet = wr && !wrAcc;
    assign udfSet = rd && isEmpty && !wr;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (ovfSet) begin
            ovf_d = 1'b1;
        end
        if (udfSet) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_param_wr_fifo.sv
// Directed self-checking bench for param_wr_fifo at DEPTH=8, DATA_W=98.
// Define PARAM_WR_FIFO_ERR_EN here as well to exercise the error flags.
module tb_param_wr_fifo;

    localparam int DATA_W = 98;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              wr = 1'b0;
    logic [DATA_W-1:0] wrData = '0;
    logic              rd = 1'b0;
    logic [DATA_W-1:0] rdData;
    logic              fifoEmpty;
    logic              fifoEmptyBar;
    logic              fifoFull;
    logic              fifoFullBar;
    logic              fifoAfull;
    logic              fifoAempty;
    logic [3:0]        fifoCnt;
`ifdef PARAM_WR_FIFO_ERR_EN
    logic              errClr = 1'b0;
    logic              ovfErr;
    logic              udfErr;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    logic [DATA_W-1:0] model [$];

    param_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wr             (wr),
        .wr_data        (wrData),
        .rd             (rd),
        .rd_data        (rdData),
        .fifo_empty     (fifoEmpty),
        .fifo_empty_bar (fifoEmptyBar),
        .fifo_full      (fifoFull),
        .fifo_full_bar  (fifoFullBar),
        .fifo_afull     (fifoAfull),
        .fifo_aempty    (fifoAempty),
        .fifo_cnt       (fifoCnt)
`ifdef PARAM_WR_FIFO_ERR_EN
        ,
        .err_clr        (errClr),
        .ovf_err        (ovfErr),
        .udf_err        (udfErr)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic iRst, input logic iFlush, input logic iWr,
                                 input logic iRd, input logic [DATA_W-1:0] iData);
        rst    = iRst;
        flush  = iFlush;
        wr     = iWr;
        rd     = iRd;
        wrData = iData;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
    endtask

    task automatic checkFlags(input string tag, input int cnt);
        checkOutput({tag, ".cnt"},      128'(fifoCnt),      128'(cnt));
        checkOutput({tag, ".empty"},    128'(fifoEmpty),    128'(cnt == 0));
        checkOutput({tag, ".emptyBar"}, 128'(fifoEmptyBar), 128'(cnt != 0));
        checkOutput({tag, ".full"},     128'(fifoFull),     128'(cnt == DEPTH));
        checkOutput({tag, ".fullBar"},  128'(fifoFullBar),  128'(cnt != DEPTH));
        checkOutput({tag, ".afull"},    128'(fifoAfull),    128'(cnt >= DEPTH - 1));
        checkOutput({tag, ".aempty"},   128'(fifoAempty),   128'(cnt <= 1));
    endtask

    initial begin
        @(negedge clk);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkFlags("reset", 0);
`ifdef PARAM_WR_FIFO_ERR_EN
        checkOutput("reset.ovf", 128'(ovfErr), 128'(0));
        checkOutput("reset.udf", 128'(udfErr), 128'(0));
`endif

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(k));
            checkFlags($sformatf("fill%0d", k), k);
            checkOutput($sformatf("fill%0d.head", k), 128'(rdData), 128'(1));
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'h99));
        checkFlags("overflow", 8);
        checkOutput("overflow.head", 128'(rdData), 128'(1));
`ifdef PARAM_WR_FIFO_ERR_EN
        checkOutput("overflow.ovf", 128'(ovfErr), 128'(1));
`endif

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, DATA_W'(9));
        checkFlags("fullRdWr", 8);
        checkOutput("fullRdWr.head", 128'(rdData), 128'(2));

        for (int k = 2; k <= 9; k++) begin
            checkOutput($sformatf("drain%0d.head", k), 128'(rdData), 128'(k));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        end
        checkFlags("drained", 0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, DATA_W'(32'hA));
        checkFlags("emptyRdWr", 1);
        checkOutput("emptyRdWr.head", 128'(rdData), 128'(32'hA));
`ifdef PARAM_WR_FIFO_ERR_EN
        checkOutput("emptyRdWr.udf", 128'(udfErr), 128'(0));
        errClr = 1'b1;
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
`ifdef PARAM_WR_FIFO_ERR_EN
        errClr = 1'b0;
        checkOutput("errClr.ovf", 128'(ovfErr), 128'(0));
`endif
        checkFlags("popA", 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        checkFlags("underflow", 0);
`ifdef PARAM_WR_FIFO_ERR_EN
        checkOutput("underflow.udf", 128'(udfErr), 128'(1));
`endif

        // Prefill three, then twenty simultaneous write/read pairs that wrap both pointers.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'h200 + k));
            model.push_back(DATA_W'(32'h200 + k));
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, {DATA_W'(k), 32'hC0DE_0000 | 32'(k)} );
            void'(model.pop_front());
            model.push_back({DATA_W'(k), 32'hC0DE_0000 | 32'(k)});
            checkOutput($sformatf("pair%0d.head", k), 128'(rdData), 128'(model[0]));
            checkOutput($sformatf("pair%0d.cnt", k), 128'(fifoCnt), 128'(3));
        end
        while (model.size() > 0) begin
            checkOutput("pairDrain.head", 128'(rdData), 128'(model[0]));
            void'(model.pop_front());
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        end
        checkFlags("pairDrained", 0);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'h11 + k));
        end
        checkFlags("preFlush", 5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, DATA_W'(32'hEE));
        checkFlags("flush", 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'h21));
        checkOutput("postFlush.head", 128'(rdData), 128'(32'h21));
        checkFlags("postFlush", 1);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'h22));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(32'h23));
        checkFlags("preRst", 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, DATA_W'(32'h24));
        checkFlags("midRst", 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
